// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: commit-trace observer beside the WB stage.
// Keeps a ring buffer of the last DEPTH retired instructions, which is read
// back by age. Also keeps retired/cycle counters, shadows one result
// register, gives a pass/fail verdict at the halt instruction, and runs a
// no-commit watchdog. It only observes the pipeline and never stalls it.
module wb_trace_monitor #(
  parameter int          XLEN       = 32,
  parameter int          DEPTH      = 16,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] HALT_INST  = 32'h00100073,
  parameter int          RESULT_REG = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [XLEN-1:0]           wb_pc,
  input  logic [31:0]               wb_inst,
  input  logic                      wb_rf_we,
  input  logic [4:0]                wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      rd_req,
  input  logic [$clog2(DEPTH)-1:0]  rd_idx,
  output logic                      rd_vld,
  output logic [XLEN-1:0]           rd_pc,
  output logic [31:0]               rd_inst,
  output logic                      rd_we,
  output logic [4:0]                rd_rd,
  output logic [XLEN-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic [31:0]               retired,
  output logic [31:0]               cycles,
  output logic [XLEN-1:0]           result,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout
);

  localparam int         IW     = $clog2(DEPTH);
  localparam int         CW     = IW + 1;
  localparam int         TW     = $clog2(TIMEOUT + 1);
  localparam logic [4:0] RES_RD = 5'(RESULT_REG);
  localparam bit         RES_EN = (RESULT_REG != 0);

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic            mem_we   [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic [IW-1:0]   wr_ptr;
  logic [TW-1:0]   idle_cnt;

  logic            frozen;
  logic            commit;
  logic            result_we;
  logic [XLEN-1:0] result_next;
  logic            halt_hit;
  logic            idle_expire;
  logic [IW-1:0]   rd_addr;
  logic            rd_hit;

  // Commit qualification, result forwarding for the halt verdict, read decode
  always_comb begin
    frozen      = done | timeout;
    commit      = wb_valid & ~frozen;
    result_we   = commit & wb_rf_we & (wb_rd == RES_RD) & RES_EN;
    result_next = result_we ? wb_data : result;
    halt_hit    = commit & (wb_inst == HALT_INST);
    idle_expire = ~frozen & ~wb_valid & (idle_cnt == TW'(TIMEOUT - 1));
    rd_addr     = wr_ptr - IW'(1) - rd_idx;
    rd_hit      = ({1'b0, rd_idx} < count);
  end

  // Trace storage; validity is tracked by count, so the array needs no reset
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_pc[wr_ptr]   <= wb_pc;
      mem_inst[wr_ptr] <= wb_inst;
      mem_we[wr_ptr]   <= wb_rf_we;
      mem_rd[wr_ptr]   <= wb_rd;
      mem_data[wr_ptr] <= wb_data;
    end
  end

  // Write pointer, occupancy, counters, result shadow, verdict and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      idle_cnt <= '0;
      retired  <= '0;
      cycles   <= '0;
      result   <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
    end else if (!frozen) begin
      cycles <= cycles + 32'd1;
      result <= result_next;
      if (commit) begin
        wr_ptr   <= wr_ptr + IW'(1);
        retired  <= retired + 32'd1;
        idle_cnt <= '0;
        if (count != CW'(DEPTH)) count <= count + CW'(1);
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
      if (halt_hit) begin
        done <= 1'b1;
        pass <= (result_next == '0);
      end
      if (idle_expire) timeout <= 1'b1;
    end
  end

  // Registered age-indexed read; fields hold when no request is made
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_pc   <= '0;
      rd_inst <= '0;
      rd_we   <= 1'b0;
      rd_rd   <= '0;
      rd_data <= '0;
    end else if (rd_req) begin
      rd_vld  <= rd_hit;
      rd_pc   <= rd_hit ? mem_pc[rd_addr]   : '0;
      rd_inst <= rd_hit ? mem_inst[rd_addr] : '0;
      rd_we   <= rd_hit ? mem_we[rd_addr]   : 1'b0;
      rd_rd   <= rd_hit ? mem_rd[rd_addr]   : '0;
      rd_data <= rd_hit ? mem_data[rd_addr] : '0;
    end else begin
      rd_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Testbench for wb_trace_monitor: directed commits and reads, with read
// responses checked by a scoreboard monitor decoupled from the stimulus.
module tb_wb_trace_monitor;

  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        wb_rf_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic        rd_vld;
  logic [31:0] rd_pc;
  logic [31:0] rd_inst;
  logic        rd_we;
  logic [4:0]  rd_rd;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic [31:0] retired;
  logic [31:0] cycles;
  logic [31:0] result;
  logic        done;
  logic        pass;
  logic        timeout;

  wb_trace_monitor #(
    .XLEN(32), .DEPTH(16), .TIMEOUT(8), .HALT_INST(HALT), .RESULT_REG(10)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_vld(rd_vld), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_we(rd_we),
    .rd_rd(rd_rd), .rd_data(rd_data),
    .count(count), .retired(retired), .cycles(cycles), .result(result),
    .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic req_d  = 1'b0;

  // Bench copy of "a read was accepted last edge"
  always @(posedge clk) req_d <= rd_req & ~rst;

  // Scoreboard monitor: compare each read response away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (req_d) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_scoreboard_empty: got rd_vld=%0b with no expected entry", rd_vld);
      end else begin
        e = q.pop_front();
        if ({rd_vld, rd_pc, rd_inst, rd_we, rd_rd, rd_data} !==
            {e.vld, e.pc, e.inst, e.we, e.rd, e.data}) begin
          n_fail++;
          $display("FAIL rd_entry: got vld=%0b pc=%h inst=%h we=%0b rd=%0d data=%h, want vld=%0b pc=%h inst=%h we=%0b rd=%0d data=%h",
                   rd_vld, rd_pc, rd_inst, rd_we, rd_rd, rd_data,
                   e.vld, e.pc, e.inst, e.we, e.rd, e.data);
        end
      end
    end else if (rd_vld !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rd_vld_spurious: got rd_vld=%0b want 0", rd_vld);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] inst,
                        input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_inst  = inst;
    wb_rf_we = we;
    wb_rd    = rd;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic vld, input logic [31:0] pc,
                    input logic [31:0] inst, input logic we, input logic [4:0] rdn,
                    input logic [31:0] data);
    exp_t e;
    e.vld = vld; e.pc = pc; e.inst = inst; e.we = we; e.rd = rdn; e.data = data;
    q.push_back(e);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_vld"},  32'(rd_vld),  32'd0);
    chk({tag, "_rd_pc"},   rd_pc,        32'd0);
    chk({tag, "_rd_inst"}, rd_inst,      32'd0);
    chk({tag, "_rd_we"},   32'(rd_we),   32'd0);
    chk({tag, "_rd_rd"},   32'(rd_rd),   32'd0);
    chk({tag, "_rd_data"}, rd_data,      32'd0);
    chk({tag, "_count"},   32'(count),   32'd0);
    chk({tag, "_retired"}, retired,      32'd0);
    chk({tag, "_cycles"},  cycles,       32'd0);
    chk({tag, "_result"},  result,       32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_pass"},    32'(pass),    32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation exceeded 100000 time units");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    do_reset();
    chk_all_zero("reset");

    // 1: three commits, newest/oldest/out-of-range reads, hold without request
    commit(32'h0, NOP, 1'b1, 5'd1, 32'd100);
    commit(32'h4, NOP, 1'b1, 5'd1, 32'd104);
    commit(32'h8, NOP, 1'b1, 5'd1, 32'd108);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_retired", retired, 32'd3);
    rd(4'd0, 1'b1, 32'h8, NOP, 1'b1, 5'd1, 32'd108);
    rd(4'd2, 1'b1, 32'h0, NOP, 1'b1, 5'd1, 32'd100);
    rd(4'd3, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0);
    rd(4'd1, 1'b1, 32'h4, NOP, 1'b1, 5'd1, 32'd104);
    tick();
    chk("t1_rd_pc_hold", rd_pc, 32'h4);
    chk("t1_rd_data_hold", rd_data, 32'd104);

    // 2: wrap past DEPTH
    do_reset();
    for (int i = 0; i < 20; i++) commit(32'(4 * i), NOP, 1'b1, 5'd1, 32'(4 * i + 100));
    chk("t2_count_sat", 32'(count), 32'd16);
    chk("t2_retired", retired, 32'd20);
    rd(4'd15, 1'b1, 32'h10, NOP, 1'b1, 5'd1, 32'h10 + 32'd100);
    rd(4'd0,  1'b1, 32'h4C, NOP, 1'b1, 5'd1, 32'h4C + 32'd100);

    // 3: a0=0 then halt -> pass; later commit ignored
    do_reset();
    commit(32'h0, 32'h00000513, 1'b1, 5'd10, 32'd0);
    commit(32'h4, HALT, 1'b0, 5'd0, 32'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_pass", 32'(pass), 32'd1);
    chk("t3_cycles", cycles, 32'd2);
    commit(32'h8, NOP, 1'b1, 5'd1, 32'd108);
    chk("t3_retired_frozen", retired, 32'd2);
    chk("t3_count_frozen", 32'(count), 32'd2);
    chk("t3_cycles_frozen", cycles, 32'd2);
    chk("t3_timeout", 32'(timeout), 32'd0);
    rd(4'd0, 1'b1, 32'h4, HALT, 1'b0, 5'd0, 32'd0);

    // 3b: halt that itself writes a0=0 uses the same-cycle value
    do_reset();
    commit(32'h0, NOP, 1'b1, 5'd10, 32'd5);
    commit(32'h4, HALT, 1'b1, 5'd10, 32'd0);
    chk("t3b_done", 32'(done), 32'd1);
    chk("t3b_pass", 32'(pass), 32'd1);
    chk("t3b_result", result, 32'd0);

    // 4: a0=5, x0 / other-reg / non-writing commits leave result alone
    do_reset();
    commit(32'h0,  NOP, 1'b1, 5'd10, 32'd5);
    commit(32'h4,  NOP, 1'b1, 5'd0,  32'd77);
    commit(32'h8,  NOP, 1'b1, 5'd11, 32'd9);
    commit(32'hC,  NOP, 1'b0, 5'd10, 32'd99);
    chk("t4_result_pre", result, 32'd5);
    chk("t4_count_x0_captured", 32'(count), 32'd4);
    commit(32'h10, HALT, 1'b0, 5'd0, 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);
    chk("t4_result", result, 32'd5);
    chk("t4_retired", retired, 32'd5);
    rd(4'd1, 1'b1, 32'hC, NOP, 1'b0, 5'd10, 32'd99);
    rd(4'd3, 1'b1, 32'h4, NOP, 1'b1, 5'd0,  32'd77);

    // 6: mid-run reset with a read request and a commit pending
    rst      = 1'b1;
    rd_req   = 1'b1;
    rd_idx   = 4'd0;
    wb_valid = 1'b1;
    wb_pc    = 32'h20;
    wb_inst  = NOP;
    tick();
    rst      = 1'b0;
    rd_req   = 1'b0;
    wb_valid = 1'b0;
    chk_all_zero("t6");

    // 5: commit on the threshold cycle wins; then a full idle run times out
    do_reset();
    repeat (7) tick();
    chk("t5_timeout_idle7", 32'(timeout), 32'd0);
    chk("t5_cycles_7", cycles, 32'd7);
    commit(32'h40, NOP, 1'b1, 5'd1, 32'd5);
    chk("t5_timeout_commit_wins", 32'(timeout), 32'd0);
    chk("t5_cycles_8", cycles, 32'd8);
    repeat (7) tick();
    chk("t5_timeout_idle7b", 32'(timeout), 32'd0);
    chk("t5_cycles_15", cycles, 32'd15);
    tick();
    chk("t5_timeout_idle8", 32'(timeout), 32'd1);
    chk("t5_cycles_16", cycles, 32'd16);
    repeat (3) tick();
    chk("t5_cycles_frozen", cycles, 32'd16);
    chk("t5_done", 32'(done), 32'd0);
    commit(32'h44, NOP, 1'b1, 5'd10, 32'd3);
    chk("t5_retired_frozen", retired, 32'd1);
    chk("t5_result_frozen", result, 32'd0);
    rd(4'd0, 1'b1, 32'h40, NOP, 1'b1, 5'd1, 32'd5);

    // reset clears a timed-out monitor
    do_reset();
    chk_all_zero("t5_rst");

    tick();
    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
